// File: rtl/updown_counter.sv
// Runtime-programmable up/down modulo counter with wrap or saturate mode,
// combinational carry lookahead for cascading, registered wrap pulse and sticky overflow.
module updown_counter #(
  parameter int unsigned Width      = 8,
  parameter logic        SatDefault = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic [Width-1:0] limit_i,
  input  logic             mode_we_i,
  input  logic             sat_mode_i,
  output logic [Width-1:0] value_o,
  output logic             at_max_o,
  output logic             at_zero_o,
  output logic             carry_o,
  output logic             wrap_o,
  output logic             overflow_o
);

  logic [Width-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             sat_q;

  logic [Width:0]   one_ext;
  logic [Width:0]   sum_up;
  logic [Width:0]   sum_dn;
  logic             above_lim;
  logic             below_lim;
  logic             is_zero;

  assign one_ext   = {{Width{1'b0}}, 1'b1};
  assign sum_up    = {1'b0, value_q} + one_ext;
  assign sum_dn    = {1'b0, value_q} - one_ext;
  assign above_lim = value_q > limit_i;
  assign below_lim = value_q < limit_i;
  assign is_zero   = value_q == '0;

  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr_i) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      value_d = (load_val_i > limit_i) ? limit_i : load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (below_lim) begin
          value_d = sum_up[Width-1:0];
        end else if (sat_q) begin
          // at or above limit: saturate onto limit (holds when already there)
          value_d = limit_i;
          ovf_d   = 1'b1;
        end else begin
          value_d = '0;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end
      end else begin
        if (above_lim) begin
          value_d = limit_i;
        end else if (is_zero) begin
          if (sat_q) begin
            ovf_d = 1'b1;
          end else begin
            value_d = limit_i;
            wrap_d  = 1'b1;
            ovf_d   = 1'b1;
          end
        end else begin
          value_d = sum_dn[Width-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sat_q   <= SatDefault;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      if (mode_we_i) begin
        sat_q <= sat_mode_i;
      end
    end
  end

  assign value_o    = value_q;
  assign wrap_o     = wrap_q;
  assign overflow_o = ovf_q;
  assign at_max_o   = value_q == limit_i;
  assign at_zero_o  = is_zero;
  assign carry_o    = en_i & ~clr_i & ~load_i & ~sat_q & (up_i ? ~below_lim : is_zero);

endmodule

// File: tb/tb_updown_counter.sv
// Directed table-driven bench for updown_counter (Width=4, wrap mode at reset).
module tb_updown_counter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i, up_i, clr_i, load_i, mode_we_i, sat_mode_i;
  logic [3:0] load_val_i, limit_i;
  logic [3:0] value_o;
  logic       at_max_o, at_zero_o, carry_o, wrap_o, overflow_o;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] lval;
    logic       en;
    logic       up;
    logic [3:0] lim;
    logic       mwe;
    logic       msat;
    logic       e_carry;
    logic [3:0] e_val;
    logic       e_wrap;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  updown_counter #(.Width(4), .SatDefault(1'b0)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .up_i       (up_i),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .limit_i    (limit_i),
    .mode_we_i  (mode_we_i),
    .sat_mode_i (sat_mode_i),
    .value_o    (value_o),
    .at_max_o   (at_max_o),
    .at_zero_o  (at_zero_o),
    .carry_o    (carry_o),
    .wrap_o     (wrap_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void add(input logic clr, input logic load, input logic [3:0] lval,
                              input logic en, input logic up, input logic [3:0] lim,
                              input logic mwe, input logic msat, input logic e_carry,
                              input logic [3:0] e_val, input logic e_wrap, input logic e_ovf);
    vec_t v;
    v.clr = clr; v.load = load; v.lval = lval; v.en = en; v.up = up; v.lim = lim;
    v.mwe = mwe; v.msat = msat; v.e_carry = e_carry; v.e_val = e_val;
    v.e_wrap = e_wrap; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic drive_idle(input logic [3:0] lim);
    clr_i = 0; load_i = 0; load_val_i = 0; en_i = 0; up_i = 0;
    limit_i = lim; mode_we_i = 0; sat_mode_i = 0;
  endtask

  initial begin
    logic [3:0] prev_val;

    //   clr load lval en up lim mwe msat | carry val wrap ovf
    for (int i = 1; i <= 9; i++) add(0, 0, 0, 1, 1, 9, 0, 0, 0, 4'(i), 0, 0);
    add(0, 0, 0,  1, 1, 9,  0, 0,  1, 0, 1, 1);   // 9 -> 0 wrap
    add(0, 0, 0,  0, 0, 9,  0, 0,  0, 0, 0, 1);   // idle: wrap drops, ovf sticky
    add(0, 1, 5,  0, 0, 9,  0, 0,  0, 5, 0, 1);
    add(1, 1, 7,  1, 1, 9,  0, 0,  0, 0, 0, 0);   // clr beats load and en
    add(0, 1, 12, 0, 0, 9,  0, 0,  0, 9, 0, 0);   // load clamped to limit
    add(0, 0, 0,  0, 0, 9,  1, 1,  0, 9, 0, 0);   // switch to sat
    add(0, 0, 0,  1, 1, 9,  0, 0,  0, 9, 0, 1);   // blocked at limit
    add(1, 0, 0,  0, 0, 9,  0, 0,  0, 0, 0, 0);
    add(0, 1, 2,  0, 0, 9,  0, 0,  0, 2, 0, 0);
    add(0, 0, 0,  1, 0, 9,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 9,  0, 0,  0, 0, 0, 0);
    add(0, 0, 0,  1, 0, 9,  0, 0,  0, 0, 0, 1);
    add(0, 0, 0,  1, 0, 9,  0, 0,  0, 0, 0, 1);
    add(1, 0, 0,  0, 0, 9,  1, 0,  0, 0, 0, 0);   // back to wrap
    add(0, 1, 8,  0, 0, 9,  0, 0,  0, 8, 0, 0);
    add(0, 0, 0,  0, 0, 3,  0, 0,  0, 8, 0, 0);   // shrink limit, no clamp
    add(0, 0, 0,  1, 1, 3,  0, 0,  1, 0, 1, 1);   // out of range up wraps
    add(1, 0, 0,  0, 0, 9,  0, 0,  0, 0, 0, 0);
    add(0, 1, 8,  0, 0, 9,  0, 0,  0, 8, 0, 0);
    add(0, 0, 0,  1, 0, 3,  0, 0,  0, 3, 0, 0);   // out of range down -> limit
    add(0, 1, 8,  0, 0, 9,  1, 1,  0, 8, 0, 0);
    add(0, 0, 0,  1, 1, 3,  0, 0,  0, 3, 0, 1);   // out of range up, sat
    add(1, 0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 0);
    add(0, 0, 0,  1, 1, 0,  0, 0,  1, 0, 1, 1);   // limit 0: every event wraps
    add(0, 0, 0,  1, 1, 0,  0, 0,  1, 0, 1, 1);
    add(0, 0, 0,  1, 1, 0,  0, 0,  1, 0, 1, 1);
    add(0, 0, 0,  1, 0, 0,  0, 0,  1, 0, 1, 1);
    add(0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 1);
    add(1, 0, 0,  0, 0, 15, 0, 0,  0, 0, 0, 0);
    add(0, 1, 14, 0, 0, 15, 0, 0,  0, 14, 0, 0);
    add(0, 0, 0,  1, 1, 15, 0, 0,  0, 15, 0, 0);
    add(0, 0, 0,  1, 1, 15, 0, 0,  1, 0, 1, 1);   // full-range wrap

    rst_ni = 1'b0;
    drive_idle(9);
    #12;
    chk("reset value", 16'(value_o), 16'd0);
    chk("reset wrap", 16'(wrap_o), 16'd0);
    chk("reset ovf", 16'(overflow_o), 16'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    prev_val = 4'd0;
    foreach (vecs[i]) begin
      clr_i = vecs[i].clr; load_i = vecs[i].load; load_val_i = vecs[i].lval;
      en_i = vecs[i].en; up_i = vecs[i].up; limit_i = vecs[i].lim;
      mode_we_i = vecs[i].mwe; sat_mode_i = vecs[i].msat;
      #3;
      chk($sformatf("v%0d carry", i), 16'(carry_o), 16'(vecs[i].e_carry));
      chk($sformatf("v%0d at_max", i), 16'(at_max_o), 16'(prev_val == vecs[i].lim));
      chk($sformatf("v%0d at_zero", i), 16'(at_zero_o), 16'(prev_val == 4'd0));
      @(posedge clk_i); #1;
      chk($sformatf("v%0d value", i), 16'(value_o), 16'(vecs[i].e_val));
      chk($sformatf("v%0d wrap", i), 16'(wrap_o), 16'(vecs[i].e_wrap));
      chk($sformatf("v%0d ovf", i), 16'(overflow_o), 16'(vecs[i].e_ovf));
      prev_val = vecs[i].e_val;
    end

    // Async reset mid-count with sat mode selected beforehand
    drive_idle(9);
    load_i = 1; load_val_i = 6; mode_we_i = 1; sat_mode_i = 1;
    @(posedge clk_i); #1;
    chk("pre-reset value", 16'(value_o), 16'd6);
    chk("pre-reset ovf", 16'(overflow_o), 16'd1);
    drive_idle(9);
    #3 rst_ni = 1'b0;
    #1;
    chk("async reset value", 16'(value_o), 16'd0);
    chk("async reset wrap", 16'(wrap_o), 16'd0);
    chk("async reset ovf", 16'(overflow_o), 16'd0);
    #1 rst_ni = 1'b1;
    drive_idle(0);
    en_i = 1; up_i = 1;
    #1;
    chk("mode after reset carry", 16'(carry_o), 16'd1);
    @(posedge clk_i); #1;
    chk("mode after reset wrap", 16'(wrap_o), 16'd1);
    chk("mode after reset ovf", 16'(overflow_o), 16'd1);

    // Async reset while the wrap pulse is high
    drive_idle(0);
    #3 rst_ni = 1'b0;
    #1;
    chk("reset clears wrap", 16'(wrap_o), 16'd0);
    chk("reset clears ovf", 16'(overflow_o), 16'd0);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("idle after reset value", 16'(value_o), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
